// File: rtl/coax_tx_scheduler_pkg.sv
// Shared types and sizes for the coax transmit scheduler and its round-robin arbiter.
package coax_tx_scheduler_pkg;

   localparam int unsigned WORD_WIDTH = 10;
   localparam int unsigned NUM_CH     = 2;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      LOAD_HIGH,
      WAIT_ACTIVE,
      WAIT_IDLE,
      TURNAROUND
   } sched_state_e;

   typedef struct packed {
      logic                  last;
      logic [WORD_WIDTH-1:0] data;
   } coax_word_t;

endpackage

// File: rtl/coax_rr_arbiter.sv
// Two-way round-robin arbiter: combinational one-hot grant, priority pointer moves past each winner.
module coax_rr_arbiter
   import coax_tx_scheduler_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] req,
   input  logic              advance,
   output logic [NUM_CH-1:0] grant_c
);

   // Channel favoured on the next tie; starts on ch0.
   logic prio;

   always_comb begin
      grant_c = '0;
      if (req[prio]) begin
         grant_c[prio] = 1'b1;
      end else if (req[~prio]) begin
         grant_c[~prio] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio <= 1'b0;
      end else if (advance && (|grant_c)) begin
         prio <= grant_c[0];
      end
   end

endmodule

// File: rtl/coax_tx_scheduler.sv
// Frame-granular scheduler sharing one coax_tx between two word streams.
// Optional watchdog on the line-drain wait: define COAX_TX_SCHED_WATCHDOG_EN.
module coax_tx_scheduler
   import coax_tx_scheduler_pkg::*;
#(
   parameter int unsigned TURNAROUND_CLOCKS = 64,
   parameter int unsigned WATCHDOG_CLOCKS   = 65536
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WORD_WIDTH-1:0] req0_data,
   input  logic [WORD_WIDTH-1:0] req1_data,
   input  logic [NUM_CH-1:0]     req_valid,
   input  logic [NUM_CH-1:0]     req_last,
   output logic [NUM_CH-1:0]     req_ready,
   output logic [WORD_WIDTH-1:0] tx_data,
   output logic                  tx_load,
   input  logic                  tx_full,
   input  logic                  tx_active,
   output logic [NUM_CH-1:0]     grant,
   output logic                  busy,
   output logic                  underrun,
   output logic                  watchdog_error
);

   localparam int unsigned TA_W = $clog2(TURNAROUND_CLOCKS + 1);

   if (TURNAROUND_CLOCKS < 1) begin : g_bad_turnaround
      $error("TURNAROUND_CLOCKS must be at least 1");
   end
   if (WATCHDOG_CLOCKS < 1) begin : g_bad_watchdog
      $error("WATCHDOG_CLOCKS must be at least 1");
   end

   sched_state_e          state, state_next;
   logic [NUM_CH-1:0]     grant_next, arb_grant;
   logic [WORD_WIDTH-1:0] tx_data_next;
   logic                  tx_load_next, busy_next, underrun_next, wd_err_next;
   logic                  last_q, last_next, started, started_next;
   logic                  tx_active_q, advance;
   logic [TA_W-1:0]       ta_cnt, ta_cnt_next;
   coax_word_t            sel_word;
   logic                  sel_valid;

`ifdef COAX_TX_SCHED_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(WATCHDOG_CLOCKS + 1);
   logic [WD_W-1:0] wd_cnt, wd_cnt_next;
`endif

   coax_rr_arbiter u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req_valid),
      .advance (advance),
      .grant_c (arb_grant)
   );

   // Owner's stream, selected by the registered grant.
   always_comb begin
      sel_word.data = grant[1] ? req1_data : req0_data;
      sel_word.last = |(grant & req_last);
      sel_valid     = |(grant & req_valid);
   end

   always_comb begin
      state_next    = state;
      grant_next    = grant;
      tx_data_next  = tx_data;
      tx_load_next  = 1'b0;
      last_next     = last_q;
      started_next  = started;
      ta_cnt_next   = '0;
      underrun_next = 1'b0;
      wd_err_next   = 1'b0;
      req_ready     = '0;
      advance       = 1'b0;
`ifdef COAX_TX_SCHED_WATCHDOG_EN
      wd_cnt_next   = '0;
`endif
      case (state)
         IDLE: begin
            if (|req_valid) begin
               advance      = 1'b1;
               grant_next   = arb_grant;
               started_next = 1'b0;
               state_next   = SEND;
            end
         end
         SEND: begin
            if (sel_valid && !tx_full) begin
               req_ready    = grant;
               tx_data_next = sel_word.data;
               tx_load_next = 1'b1;
               last_next    = sel_word.last;
               started_next = 1'b1;
               state_next   = LOAD_HIGH;
            end
            // Line drained before the owner supplied the next word.
            if (started && tx_active_q && !tx_active) begin
               underrun_next = 1'b1;
            end
         end
         LOAD_HIGH: begin
            state_next = last_q ? WAIT_ACTIVE : SEND;
         end
         WAIT_ACTIVE: begin
            if (tx_active) begin
               state_next = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (!tx_active) begin
               grant_next = '0;
               state_next = TURNAROUND;
            end
         end
         TURNAROUND: begin
            if (ta_cnt == TA_W'(TURNAROUND_CLOCKS - 1)) begin
               state_next = IDLE;
            end else begin
               ta_cnt_next = ta_cnt + TA_W'(1);
            end
         end
         default: begin
            grant_next = '0;
            state_next = WAIT_IDLE;
         end
      endcase
`ifdef COAX_TX_SCHED_WATCHDOG_EN
      // Watchdog spans both drain-wait states; abort frees the line owner.
      if ((state == WAIT_ACTIVE) || (state == WAIT_IDLE)) begin
         if (wd_cnt == WD_W'(WATCHDOG_CLOCKS - 1)) begin
            wd_err_next = 1'b1;
            grant_next  = '0;
            state_next  = TURNAROUND;
         end else begin
            wd_cnt_next = wd_cnt + WD_W'(1);
         end
      end
`endif
      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= WAIT_IDLE;
         grant          <= '0;
         tx_data        <= '0;
         tx_load        <= 1'b0;
         busy           <= 1'b1;
         underrun       <= 1'b0;
         watchdog_error <= 1'b0;
         last_q         <= 1'b0;
         started        <= 1'b0;
         tx_active_q    <= 1'b0;
         ta_cnt         <= '0;
      end else begin
         state          <= state_next;
         grant          <= grant_next;
         tx_data        <= tx_data_next;
         tx_load        <= tx_load_next;
         busy           <= busy_next;
         underrun       <= underrun_next;
         watchdog_error <= wd_err_next;
         last_q         <= last_next;
         started        <= started_next;
         tx_active_q    <= tx_active;
         ta_cnt         <= ta_cnt_next;
      end
   end

`ifdef COAX_TX_SCHED_WATCHDOG_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt_next;
      end
   end
`endif

endmodule

// File: tb/tb_coax_tx_scheduler.sv
// Directed bench for coax_tx_scheduler: vector table for a plain frame, hand sequences for the corners.
module tb_coax_tx_scheduler;

   localparam int unsigned TA = 8;
   localparam int unsigned WD = 40;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] req0_data, req1_data;
   logic [1:0] req_valid, req_last, req_ready;
   logic [9:0] tx_data;
   logic       tx_load, tx_full, tx_active;
   logic [1:0] grant;
   logic       busy, underrun, watchdog_error;

   int tests = 0;
   int fails = 0;

   coax_tx_scheduler #(.TURNAROUND_CLOCKS(TA), .WATCHDOG_CLOCKS(WD)) dut (
      .clk(clk), .reset(reset),
      .req0_data(req0_data), .req1_data(req1_data),
      .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
      .tx_data(tx_data), .tx_load(tx_load), .tx_full(tx_full), .tx_active(tx_active),
      .grant(grant), .busy(busy), .underrun(underrun), .watchdog_error(watchdog_error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] valid;
      logic [1:0] last;
      logic [9:0] d0;
      logic       full;
      logic       active;
      logic [1:0] exp_ready;
      logic       exp_load;
      logic [9:0] exp_data;
      logic [1:0] exp_grant;
      logic       exp_busy;
      logic       exp_under;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Waits for a grant, checking the turnaround gap from the current negedge.
   task automatic wait_grant(input logic [1:0] exp_g, input string tag);
      int waited = 0;
      while (grant == 2'b00 && waited < 100) begin
         step();
         waited++;
      end
      chk({tag, "_gap"}, 32'(waited), 32'(TA + 1));
      chk({tag, "_grant"}, 32'(grant), 32'(exp_g));
   endtask

   task automatic frame(input logic [1:0] exp_g, input int n, input logic [9:0] base, input string tag);
      bit ok;
      req_valid = 2'b11; req_last = 2'b00;
      req0_data = base;  req1_data = base;
      tx_full = 1'b0;    tx_active = 1'b0;
      wait_grant(exp_g, tag);
      for (int w = 0; w < n; w++) begin
         req0_data = base + 10'(w);
         req1_data = base + 10'(w);
         req_last  = (w == n - 1) ? 2'b11 : 2'b00;
         ok = 1'b0;
         for (int k = 0; k < 6; k++) begin
            step();
            if (tx_load) begin
               ok = 1'b1;
               break;
            end
         end
         chk({tag, "_load_seen"}, 32'(ok), 32'd1);
         chk({tag, "_data"}, 32'(tx_data), 32'(base + 10'(w)));
      end
      req_valid = 2'b00; req_last = 2'b00; tx_active = 1'b1;
      step(); step();
      chk({tag, "_grant_held"}, 32'(grant), 32'(exp_g));
      tx_active = 1'b0;
      step();
      chk({tag, "_grant_released"}, 32'(grant), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, failed count %0d", fails);
      $fatal(1, "timeout");
   end

   initial begin
      bit ok;
      bit seen;
      int n;

      vecs[0] = '{2'b01, 2'b00, 10'h101, 1'b0, 1'b0, 2'b00, 1'b0, 10'h000, 2'b01, 1'b1, 1'b0};
      vecs[1] = '{2'b01, 2'b00, 10'h101, 1'b0, 1'b0, 2'b01, 1'b1, 10'h101, 2'b01, 1'b1, 1'b0};
      vecs[2] = '{2'b01, 2'b00, 10'h102, 1'b0, 1'b0, 2'b00, 1'b0, 10'h101, 2'b01, 1'b1, 1'b0};
      vecs[3] = '{2'b01, 2'b00, 10'h102, 1'b0, 1'b0, 2'b01, 1'b1, 10'h102, 2'b01, 1'b1, 1'b0};
      vecs[4] = '{2'b01, 2'b01, 10'h103, 1'b0, 1'b0, 2'b00, 1'b0, 10'h102, 2'b01, 1'b1, 1'b0};
      vecs[5] = '{2'b01, 2'b01, 10'h103, 1'b0, 1'b0, 2'b01, 1'b1, 10'h103, 2'b01, 1'b1, 1'b0};
      vecs[6] = '{2'b00, 2'b00, 10'h000, 1'b0, 1'b1, 2'b00, 1'b0, 10'h103, 2'b01, 1'b1, 1'b0};
      vecs[7] = '{2'b00, 2'b00, 10'h000, 1'b0, 1'b1, 2'b00, 1'b0, 10'h103, 2'b01, 1'b1, 1'b0};
      vecs[8] = '{2'b00, 2'b00, 10'h000, 1'b0, 1'b1, 2'b00, 1'b0, 10'h103, 2'b01, 1'b1, 1'b0};
      vecs[9] = '{2'b00, 2'b00, 10'h000, 1'b0, 1'b0, 2'b00, 1'b0, 10'h103, 2'b00, 1'b1, 1'b0};

      reset = 1'b1;
      req0_data = '0; req1_data = '0; req_valid = '0; req_last = '0;
      tx_full = 1'b0; tx_active = 1'b0;
      step(); step();
      chk("rst_tx_load", 32'(tx_load), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      chk("rst_watchdog", 32'(watchdog_error), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      reset = 1'b0;

      // Out of reset: WAIT_IDLE sees an idle line, then a full turnaround.
      n = 0;
      while (busy && n < 50) begin
         step();
         n++;
      end
      chk("reset_to_idle_clocks", 32'(n), 32'(TA + 1));

      // Single ch0 frame of three words.
      foreach (vecs[i]) begin
         req_valid = vecs[i].valid; req_last = vecs[i].last; req0_data = vecs[i].d0;
         tx_full = vecs[i].full; tx_active = vecs[i].active;
         #1;
         chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
         step();
         chk($sformatf("v%0d_load", i), 32'(tx_load), 32'(vecs[i].exp_load));
         chk($sformatf("v%0d_data", i), 32'(tx_data), 32'(vecs[i].exp_data));
         chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
         chk($sformatf("v%0d_underrun", i), 32'(underrun), 32'(vecs[i].exp_under));
      end

      // Both channels always requesting: ownership alternates, starting after ch0.
      frame(2'b10, 2, 10'h010, "rr0");
      frame(2'b01, 1, 10'h020, "rr1");
      frame(2'b10, 3, 10'h030, "rr2");
      frame(2'b01, 2, 10'h040, "rr3");

      // tx_full back-pressure mid-frame, then underrun and recovery.
      req_valid = 2'b01; req_last = 2'b00; req0_data = 10'h155;
      wait_grant(2'b01, "single");
      step();
      chk("full_w0_load", 32'(tx_load), 32'd1);
      chk("full_w0_data", 32'(tx_data), 32'h155);
      tx_active = 1'b1; tx_full = 1'b1; req0_data = 10'h2AA;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("full_ready_%0d", i), 32'(req_ready), 32'd0);
         step();
         chk($sformatf("full_load_%0d", i), 32'(tx_load), 32'd0);
      end
      tx_full = 1'b0;
      #1;
      chk("full_release_ready", 32'(req_ready), 32'd1);
      step();
      chk("full_release_load", 32'(tx_load), 32'd1);
      chk("full_release_data", 32'(tx_data), 32'h2AA);
      req_valid = 2'b00;
      step(); step();
      tx_active = 1'b0;
      step();
      chk("underrun_pulse", 32'(underrun), 32'd1);
      chk("underrun_owner_kept", 32'(grant), 32'd1);
      step();
      chk("underrun_one_clock", 32'(underrun), 32'd0);
      req_valid = 2'b01; req_last = 2'b01; req0_data = 10'h0F0;
      step();
      chk("underrun_reload_load", 32'(tx_load), 32'd1);
      chk("underrun_reload_data", 32'(tx_data), 32'h0F0);
      req_valid = 2'b00; req_last = 2'b00; tx_active = 1'b1;
      step(); step();
      tx_active = 1'b0;
      step();
      chk("underrun_frame_end", 32'(grant), 32'd0);

      // Reset while a word is on the line: wait for line idle plus turnaround.
      req_valid = 2'b10; req1_data = 10'h3C3;
      wait_grant(2'b10, "pre_reset");
      step();
      chk("pre_reset_load", 32'(tx_load), 32'd1);
      tx_active = 1'b1;
      #2 reset = 1'b1;
      #1;
      chk("midrst_tx_load", 32'(tx_load), 32'd0);
      chk("midrst_tx_data", 32'(tx_data), 32'd0);
      chk("midrst_grant", 32'(grant), 32'd0);
      chk("midrst_req_ready", 32'(req_ready), 32'd0);
      chk("midrst_underrun", 32'(underrun), 32'd0);
      step();
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (grant != 2'b00) seen = 1'b1;
      end
      chk("midrst_no_grant_while_active", 32'(seen), 32'd0);
      tx_active = 1'b0;
      step();
      frame(2'b01, 1, 10'h200, "post_reset");

`ifdef COAX_TX_SCHED_WATCHDOG_EN
      // Line never drains: watchdog aborts after WD clocks in the wait states.
      req_valid = 2'b01; req_last = 2'b01; req0_data = 10'h1E1;
      wait_grant(2'b01, "wd");
      step();
      chk("wd_load", 32'(tx_load), 32'd1);
      req_valid = 2'b00; req_last = 2'b00; tx_active = 1'b1;
      n = 0;
      ok = 1'b0;
      while (n < 200) begin
         step();
         n++;
         if (watchdog_error) begin
            ok = 1'b1;
            break;
         end
      end
      chk("wd_fired", 32'(ok), 32'd1);
      chk("wd_clocks", 32'(n), 32'(WD + 1));
      chk("wd_grant_cleared", 32'(grant), 32'd0);
      step();
      chk("wd_one_clock", 32'(watchdog_error), 32'd0);
      tx_active = 1'b0;
`else
      chk("wd_disabled_low", 32'(watchdog_error), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
